ferry_scheduler: RTL and testbench
==================================

Name: ferry_scheduler

Overview:
- Controller that sequences the single-seat ferry between two river banks for a man with three possessions: wolf, goat and cabbage.
- Each trip, it accepts or generates a departure request, checks that the request is legal and safe, times the crossing, and updates the four bank registers.
- Two modes: manual (requests come in through a valid/ready handshake) and auto (a built-in 7-trip solution is replayed).
- Its bank outputs are the state a formal harness checks with cover/assert.

Parameters:
- TRIP_CYCLES, 4, cycles the boat spends in transit per crossing; legal range >= 1.
- MOVE_W, 8, width of the trip counter.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a new session; honoured only in IDLE or DONE
- auto_en  in  1  mode select, sampled when start is accepted; 1 = auto, 0 = manual
- dep_valid  in  1  manual departure request
- dep_cargo  in  2  cargo for the request: 0 none, 1 wolf, 2 goat, 3 cabbage
- dep_ready  out  1  high in READY when in manual mode
- dep_err  out  1  one-cycle pulse when a request is rejected
- sailing  out  1  high while the boat is in transit
- cargo_q  out  2  cargo currently aboard; 0 when not sailing
- bank_w, bank_g, bank_c, bank_m  out  1 each  bank of wolf, goat, cabbage, man (0 = start bank, 1 = far bank)
- moves  out  MOVE_W  count of completed crossings, saturating
- done  out  1  high in DONE

Behaviour:
- Reset (asynchronous, rst_n=0):
  - state = IDLE; all bank_* = 0.
  - moves = 0, cargo_q = 0, timer = 0, step = 0, auto_q = 0.
  - dep_ready, dep_err, sailing, done all = 0.
  - Reset asserted mid-trip aborts the trip; no partial bank update.
- States: IDLE, READY, SAIL, DONE.
- IDLE or DONE, start=1:
  - Clear all banks and moves; latch auto_q = auto_en; step = 0; go to READY.
  - done is cleared on the same edge.
- start is ignored in READY and SAIL.
- Request presented in READY:
  - Manual mode: request = dep_cargo, presented when dep_valid && dep_ready.
  - Auto mode: dep_ready = 0; request = ROM[step], presented every READY cycle.
  - ROM sequence: goat, none, wolf, goat, cabbage, none, goat.
- Legality check (combinational, done by the sub-module):
  - Illegal cargo: cargo != 0 and the cargo's bank != bank_m.
  - Item x "remains" when bank_x == bank_m and x != cargo.
  - Unsafe: (wolf and goat both remain) or (goat and cabbage both remain).
  - The request is legal when it is neither illegal cargo nor unsafe.
- Handling a presented request:
  - Illegal or unsafe: dep_err = 1 for the next cycle only; state stays READY; no other change.
  - Legal: latch cargo_q; timer = TRIP_CYCLES-1; sailing = 1; go to SAIL.
  - An accept is a single edge; dep_valid held high afterwards is not re-sampled until READY returns.
- Auto mode: an auto request is never rejected. This is a formal assert; if it fails, that is a design bug.
- SAIL:
  - timer != 0: decrement timer.
  - timer == 0 (arrival edge):
    - bank_m toggles; the cargo item's bank toggles.
    - moves = moves + 1, saturating at all-ones; step = step + 1 (auto mode).
    - cargo_q = 0; sailing = 0.
    - Next state is DONE if the updated bank_w, bank_g and bank_c are all 1, otherwise READY.
- Latency:
  - Request accepted at edge N → sailing high from N+1.
  - Banks update at edge N+TRIP_CYCLES.
  - The next request can be accepted at edge N+TRIP_CYCLES+1 at the earliest.
- Auto session: done at edge 7*(TRIP_CYCLES+1)+1 after the start edge; moves = 7.
- Invariants, all asserted:
  - The far bank is never unsafe while the man is absent, and neither is the start bank.
  - sailing implies state == SAIL.
  - dep_ready and sailing are never high together.
  - done implies bank_w, bank_g, bank_c are all 1.
- Simultaneous dep_valid and start in READY: start is ignored and the request is handled.

Decomposition:
- Package ferry_pkg holds:
  - cargo encoding constants (CARGO_NONE/WOLF/GOAT/CABBAGE);
  - the state enum;
  - the 7-entry solution ROM constant;
  - SOLUTION_LEN = 7.
- Sub-module ferry_safety_check is purely combinational:
  - inputs: banks, bank_m, cargo;
  - outputs: legal, unsafe, wrong_bank.
- The safety checker is reused by the formal harness for its invariants.

Test Plan:
- Auto run, TRIP_CYCLES=4: start=1, auto_en=1 → done at edge 36; moves=7; all banks 1; dep_err never pulses.
- Manual, after reset: request wolf → dep_err pulse (goat and cabbage left alone); state READY; banks unchanged.
- Manual, after reset: request goat → sailing for 4 cycles; then bank_g=1, bank_m=1, moves=1.
- Manual, man on far bank with bank_w=0: request wolf → dep_err (wrong bank); no transit.
- Reset deasserted then asserted during SAIL at timer=2 → all outputs 0 immediately; a fresh start restarts from the start bank.
- TRIP_CYCLES=1, manual: the full 7-step solution in back-to-back handshakes → done 14 cycles after the first accept; a start issued in DONE clears banks and moves.

Source files
------------

// File: rtl/ferry_pkg.sv
// Shared definitions for the ferry scheduler: cargo encoding, controller
// states and the built-in 7-trip solution replayed in auto mode.
package ferry_pkg;

  localparam logic [1:0] CARGO_NONE    = 2'd0;
  localparam logic [1:0] CARGO_WOLF    = 2'd1;
  localparam logic [1:0] CARGO_GOAT    = 2'd2;
  localparam logic [1:0] CARGO_CABBAGE = 2'd3;

  typedef enum logic [1:0] {StIdle, StReady, StSail, StDone} state_e;

  localparam int unsigned SOLUTION_LEN = 7;

  // Entry i lives in bits [2*i+1:2*i]; entry 0 is the first trip.
  localparam logic [2*SOLUTION_LEN-1:0] SOLUTION_ROM = {
    CARGO_GOAT, CARGO_NONE, CARGO_CABBAGE, CARGO_GOAT, CARGO_WOLF, CARGO_NONE, CARGO_GOAT
  };

  function automatic logic [1:0] rom_cargo(input logic [2:0] step);
    if (step >= 3'(SOLUTION_LEN)) begin
      return CARGO_NONE;
    end
    return SOLUTION_ROM[{step, 1'b0} +: 2];
  endfunction

endpackage

// File: rtl/ferry_safety_check.sv
// Combinational legality check of a proposed crossing.
// Ports:
//   bank_w/bank_g/bank_c/bank_m : current bank of wolf, goat, cabbage, man
//   cargo                       : proposed cargo (ferry_pkg encoding)
//   wrong_bank                  : cargo item is not on the man's bank
//   unsafe                      : an unattended pair would be left together
//   legal                       : neither wrong_bank nor unsafe
module ferry_safety_check
  import ferry_pkg::*;
(
  input  logic       bank_w,
  input  logic       bank_g,
  input  logic       bank_c,
  input  logic       bank_m,
  input  logic [1:0] cargo,
  output logic       legal,
  output logic       unsafe,
  output logic       wrong_bank
);

  logic rem_w, rem_g, rem_c;

  // An item "remains" when it is on the departure bank and not aboard.
  assign rem_w = (bank_w == bank_m) && (cargo != CARGO_WOLF);
  assign rem_g = (bank_g == bank_m) && (cargo != CARGO_GOAT);
  assign rem_c = (bank_c == bank_m) && (cargo != CARGO_CABBAGE);

  always_comb begin
    wrong_bank = 1'b0;
    unique case (cargo)
      CARGO_NONE:    wrong_bank = 1'b0;
      CARGO_WOLF:    wrong_bank = (bank_w != bank_m);
      CARGO_GOAT:    wrong_bank = (bank_g != bank_m);
      CARGO_CABBAGE: wrong_bank = (bank_c != bank_m);
      default:       wrong_bank = 1'b0;
    endcase
  end

  assign unsafe = (rem_w && rem_g) || (rem_g && rem_c);
  assign legal  = !unsafe && !wrong_bank;

endmodule

// File: rtl/ferry_scheduler.sv
// Ferry crossing controller for the wolf/goat/cabbage puzzle.
// Ports:
//   clk, rst_n            : clock, asynchronous active-low reset
//   start, auto_en        : start a session (IDLE/DONE only), mode select
//   dep_valid, dep_cargo  : manual departure request handshake
//   dep_ready             : manual request can be taken (READY, manual mode)
//   dep_err               : one-cycle pulse after a rejected request
//   sailing, cargo_q      : boat in transit and its cargo
//   bank_w/g/c/m          : bank of each item and the man (1 = far bank)
//   moves                 : completed crossings, saturating
//   done                  : all three items on the far bank
module ferry_scheduler
  import ferry_pkg::*;
#(
  parameter int unsigned TRIP_CYCLES = 4,
  parameter int unsigned MOVE_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              auto_en,
  input  logic              dep_valid,
  input  logic [1:0]        dep_cargo,
  output logic              dep_ready,
  output logic              dep_err,
  output logic              sailing,
  output logic [1:0]        cargo_q,
  output logic              bank_w,
  output logic              bank_g,
  output logic              bank_c,
  output logic              bank_m,
  output logic [MOVE_W-1:0] moves,
  output logic              done
);

  localparam int unsigned TIMER_W = (TRIP_CYCLES > 1) ? $clog2(TRIP_CYCLES) : 1;
  localparam logic [TIMER_W-1:0] TimerLoad = TIMER_W'(TRIP_CYCLES - 1);

  state_e              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [2:0]          step_q, step_d;
  logic                auto_q, auto_d;
  logic                err_d;
  logic [1:0]          cargo_d;
  logic                bank_w_d, bank_g_d, bank_c_d, bank_m_d;
  logic [MOVE_W-1:0]   moves_d;

  logic       req_valid;
  logic [1:0] req_cargo;
  logic       legal, unsafe, wrong_bank;

  assign req_cargo = auto_q ? rom_cargo(step_q) : dep_cargo;
  assign req_valid = (state_q == StReady) && (auto_q || dep_valid);

  ferry_safety_check u_check (
    .bank_w     (bank_w),
    .bank_g     (bank_g),
    .bank_c     (bank_c),
    .bank_m     (bank_m),
    .cargo      (req_cargo),
    .legal      (legal),
    .unsafe     (unsafe),
    .wrong_bank (wrong_bank)
  );

  always_comb begin
    state_d  = state_q;
    timer_d  = timer_q;
    step_d   = step_q;
    auto_d   = auto_q;
    err_d    = 1'b0;
    cargo_d  = cargo_q;
    bank_w_d = bank_w;
    bank_g_d = bank_g;
    bank_c_d = bank_c;
    bank_m_d = bank_m;
    moves_d  = moves;

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          bank_w_d = 1'b0;
          bank_g_d = 1'b0;
          bank_c_d = 1'b0;
          bank_m_d = 1'b0;
          moves_d  = '0;
          auto_d   = auto_en;
          step_d   = '0;
          state_d  = StReady;
        end
      end
      StReady: begin
        if (req_valid) begin
          if (legal) begin
            cargo_d = req_cargo;
            timer_d = TimerLoad;
            state_d = StSail;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StSail: begin
        if (timer_q != '0) begin
          timer_d = timer_q - TIMER_W'(1);
        end else begin
          bank_m_d = ~bank_m;
          if (cargo_q == CARGO_WOLF)    bank_w_d = ~bank_w;
          if (cargo_q == CARGO_GOAT)    bank_g_d = ~bank_g;
          if (cargo_q == CARGO_CABBAGE) bank_c_d = ~bank_c;
          if (moves != '1) moves_d = moves + MOVE_W'(1);
          if (auto_q) step_d = step_q + 3'd1;
          cargo_d = CARGO_NONE;
          state_d = (bank_w_d && bank_g_d && bank_c_d) ? StDone : StReady;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      timer_q <= '0;
      step_q  <= '0;
      auto_q  <= 1'b0;
      dep_err <= 1'b0;
      cargo_q <= CARGO_NONE;
      bank_w  <= 1'b0;
      bank_g  <= 1'b0;
      bank_c  <= 1'b0;
      bank_m  <= 1'b0;
      moves   <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      step_q  <= step_d;
      auto_q  <= auto_d;
      dep_err <= err_d;
      cargo_q <= cargo_d;
      bank_w  <= bank_w_d;
      bank_g  <= bank_g_d;
      bank_c  <= bank_c_d;
      bank_m  <= bank_m_d;
      moves   <= moves_d;
    end
  end

  assign dep_ready = (state_q == StReady) && !auto_q;
  assign sailing   = (state_q == StSail);
  assign done      = (state_q == StDone);

  // The built-in solution must never propose an illegal trip.
  a_auto_legal: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == StReady && auto_q) |-> legal);
  a_ready_sail: assert property (@(posedge clk) disable iff (!rst_n)
    !(dep_ready && sailing));
  a_done_banks: assert property (@(posedge clk) disable iff (!rst_n)
    done |-> (bank_w && bank_g && bank_c));

endmodule

// File: tb/tb_ferry_scheduler.sv
module tb_ferry_scheduler;

  localparam int T = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0, auto_en = 1'b0, dep_valid = 1'b0;
  logic [1:0] dep_cargo = 2'd0;
  logic       dep_ready, dep_err, sailing, done;
  logic [1:0] cargo_q;
  logic       bank_w, bank_g, bank_c, bank_m;
  logic [7:0] moves;

  // Second instance with one-cycle crossings for the back-to-back scenario.
  logic       start1 = 1'b0, dep_valid1 = 1'b0;
  logic [1:0] dep_cargo1 = 2'd0;
  logic       dep_ready1, dep_err1, sailing1, done1;
  logic [1:0] cargo_q1;
  logic       bank_w1, bank_g1, bank_c1, bank_m1;
  logic [7:0] moves1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ferry_scheduler #(.TRIP_CYCLES(T), .MOVE_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .auto_en(auto_en),
    .dep_valid(dep_valid), .dep_cargo(dep_cargo), .dep_ready(dep_ready),
    .dep_err(dep_err), .sailing(sailing), .cargo_q(cargo_q),
    .bank_w(bank_w), .bank_g(bank_g), .bank_c(bank_c), .bank_m(bank_m),
    .moves(moves), .done(done)
  );

  ferry_scheduler #(.TRIP_CYCLES(1), .MOVE_W(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .auto_en(1'b0),
    .dep_valid(dep_valid1), .dep_cargo(dep_cargo1), .dep_ready(dep_ready1),
    .dep_err(dep_err1), .sailing(sailing1), .cargo_q(cargo_q1),
    .bank_w(bank_w1), .bank_g(bank_g1), .bank_c(bank_c1), .bank_m(bank_m1),
    .moves(moves1), .done(done1)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0; dep_valid = 1'b0; start1 = 1'b0; dep_valid1 = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic start_session(input logic a);
    start = 1'b1;
    auto_en = a;
    tick();
    start = 1'b0;
  endtask

  // Reference legality from the puzzle rules; far[0] is the man, 1..3 the items.
  function automatic bit model_legal(input bit far[4], input int c);
    bit rem[4];
    if (c != 0 && far[c] != far[0]) return 1'b0;
    for (int x = 1; x < 4; x++) rem[x] = (far[x] == far[0]) && (x != c);
    return !((rem[1] && rem[2]) || (rem[2] && rem[3]));
  endfunction

  task automatic test_reset();
    do_reset();
    tests++;
    if ({bank_w, bank_g, bank_c, bank_m, moves, cargo_q} !== 14'd0) begin
      fails++;
      $display("FAIL reset_state: banks/moves/cargo=%b required 0",
               {bank_w, bank_g, bank_c, bank_m, moves, cargo_q});
    end
    tests++;
    if ({dep_ready, dep_err, sailing, done} !== 4'd0) begin
      fails++;
      $display("FAIL reset_flags: got %b required 0000", {dep_ready, dep_err, sailing, done});
    end
    tests++;
    if ({bank_w1, bank_g1, bank_c1, bank_m1, moves1, dep_ready1, sailing1, done1} !== 15'd0) begin
      fails++;
      $display("FAIL reset_dut1: got %b required 0",
               {bank_w1, bank_g1, bank_c1, bank_m1, moves1, dep_ready1, sailing1, done1});
    end
  endtask

  task automatic test_auto();
    int  cnt = 0;
    bit  err_seen = 0, rdy_seen = 0;
    do_reset();
    start_session(1'b1);
    // done is high after edge 7*(T+1)+1 counting the start edge as edge 1.
    while (!done && cnt < 200) begin
      tick();
      cnt++;
      if (dep_err) err_seen = 1;
      if (dep_ready) rdy_seen = 1;
    end
    tests++;
    if (cnt !== 7 * (T + 1)) begin
      fails++;
      $display("FAIL auto_done_time: edges after start=%0d required %0d", cnt, 7 * (T + 1));
    end
    tests++;
    if (moves !== 8'd7) begin
      fails++;
      $display("FAIL auto_moves: got %0d required 7", moves);
    end
    tests++;
    if ({bank_w, bank_g, bank_c, bank_m} !== 4'b1111) begin
      fails++;
      $display("FAIL auto_banks: got %b required 1111", {bank_w, bank_g, bank_c, bank_m});
    end
    tests++;
    if ({err_seen, rdy_seen} !== 2'b00) begin
      fails++;
      $display("FAIL auto_err_ready: err/ready seen=%b required 00", {err_seen, rdy_seen});
    end
  endtask

  task automatic test_manual_basic();
    bit sail_ok = 1;
    do_reset();
    start_session(1'b0);
    tests++;
    if (dep_ready !== 1'b1) begin
      fails++;
      $display("FAIL manual_ready: got %b required 1", dep_ready);
    end
    // Wolf first leaves goat with cabbage.
    dep_valid = 1'b1; dep_cargo = 2'd1;
    tick();
    dep_valid = 1'b0;
    tests++;
    if ({dep_err, sailing, dep_ready, bank_w, bank_g, bank_c, bank_m} !== 7'b1010000) begin
      fails++;
      $display("FAIL wolf_reject: err,sail,ready,banks=%b required 1010000",
               {dep_err, sailing, dep_ready, bank_w, bank_g, bank_c, bank_m});
    end
    tick();
    tests++;
    if (dep_err !== 1'b0) begin
      fails++;
      $display("FAIL err_pulse_width: got %b required 0", dep_err);
    end
    // Goat together with start: start must be ignored.
    dep_valid = 1'b1; dep_cargo = 2'd2; start = 1'b1;
    tick();
    dep_valid = 1'b0; start = 1'b0;
    tests++;
    if ({sailing, cargo_q, dep_ready} !== 4'b1100) begin
      fails++;
      $display("FAIL goat_accept: sail,cargo,ready=%b required 1100", {sailing, cargo_q, dep_ready});
    end
    for (int i = 1; i < T; i++) begin
      tick();
      if (sailing !== 1'b1) sail_ok = 0;
    end
    tests++;
    if (!sail_ok) begin
      fails++;
      $display("FAIL goat_transit: sailing dropped early, required high for %0d cycles", T);
    end
    tick();
    tests++;
    if ({sailing, cargo_q, bank_w, bank_g, bank_c, bank_m, moves} !== {7'b0000101, 8'd1}) begin
      fails++;
      $display("FAIL goat_arrive: sail,cargo,banks,moves=%b required 0000101_00000001",
               {sailing, cargo_q, bank_w, bank_g, bank_c, bank_m, moves});
    end
  endtask

  task automatic test_wrong_bank();
    // Man is on the far bank, wolf is still on the start bank.
    dep_valid = 1'b1; dep_cargo = 2'd1;
    tick();
    dep_valid = 1'b0;
    tests++;
    if ({dep_err, sailing, bank_w, bank_m} !== 4'b1001) begin
      fails++;
      $display("FAIL wrong_bank: err,sail,bank_w,bank_m=%b required 1001",
               {dep_err, sailing, bank_w, bank_m});
    end
  endtask

  task automatic test_reset_midtrip();
    do_reset();
    start_session(1'b0);
    dep_valid = 1'b1; dep_cargo = 2'd2;
    tick();
    dep_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    #1;
    tests++;
    if ({sailing, cargo_q, bank_w, bank_g, bank_c, bank_m, moves, dep_ready, done} !== 17'd0) begin
      fails++;
      $display("FAIL midtrip_reset: outputs=%b required 0",
               {sailing, cargo_q, bank_w, bank_g, bank_c, bank_m, moves, dep_ready, done});
    end
    tick();
    rst_n = 1'b1;
    tick();
    start_session(1'b0);
    dep_valid = 1'b1; dep_cargo = 2'd2;
    tick();
    dep_valid = 1'b0;
    repeat (T) tick();
    tests++;
    if ({bank_w, bank_g, bank_c, bank_m, moves} !== {4'b0101, 8'd1}) begin
      fails++;
      $display("FAIL restart_trip: banks,moves=%b required 0101_00000001",
               {bank_w, bank_g, bank_c, bank_m, moves});
    end
  endtask

  task automatic test_random();
    bit far[4];
    int mv = 0;
    do_reset();
    start_session(1'b0);
    for (int x = 0; x < 4; x++) far[x] = 0;
    for (int k = 0; k < 60; k++) begin
      int c;
      bit lg, all_far;
      all_far = far[1] && far[2] && far[3];
      if (all_far) begin
        start_session(1'b0);
        for (int x = 0; x < 4; x++) far[x] = 0;
        mv = 0;
      end
      c = int'($urandom_range(0, 3));
      lg = model_legal(far, c);
      dep_valid = 1'b1; dep_cargo = 2'(c);
      tick();
      dep_valid = 1'b0;
      tests++;
      if ({dep_err, sailing} !== {!lg, lg}) begin
        fails++;
        $display("FAIL rand_decide[%0d] cargo=%0d: err,sail=%b required %b",
                 k, c, {dep_err, sailing}, {!lg, lg});
      end
      if (lg) begin
        repeat (T) tick();
        far[0] = !far[0];
        if (c != 0) far[c] = !far[c];
        mv++;
        all_far = far[1] && far[2] && far[3];
        tests++;
        if ({bank_w, bank_g, bank_c, bank_m, moves, done} !==
            {far[1], far[2], far[3], far[0], 8'(mv), all_far}) begin
          fails++;
          $display("FAIL rand_arrive[%0d]: banks,moves,done=%b required %b", k,
                   {bank_w, bank_g, bank_c, bank_m, moves, done},
                   {far[1], far[2], far[3], far[0], 8'(mv), all_far});
        end
      end else begin
        tick();
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] sol [7] = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2};
    int  i = 0, edges = 0;
    bit  prev, err_seen = 0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    dep_valid1 = 1'b1; dep_cargo1 = sol[0];
    tick();
    prev = sailing1;
    i = 1;
    dep_cargo1 = sol[1];
    while (!done1 && edges < 100) begin
      tick();
      edges++;
      if (dep_err1) err_seen = 1;
      if (sailing1 && !prev) begin
        i++;
        if (i < 7) dep_cargo1 = sol[i];
      end
      prev = sailing1;
    end
    // Done is high 13 edges after the first accept edge (edge 14 counting it as 1).
    tests++;
    if (edges !== 13) begin
      fails++;
      $display("FAIL b2b_done_time: edges after first accept=%0d required 13", edges);
    end
    tests++;
    if ({moves1, bank_w1, bank_g1, bank_c1, bank_m1, err_seen} !== {8'd7, 4'b1111, 1'b0}) begin
      fails++;
      $display("FAIL b2b_final: moves,banks,err=%b required 00000111_1111_0",
               {moves1, bank_w1, bank_g1, bank_c1, bank_m1, err_seen});
    end
    dep_valid1 = 1'b0;
    start1 = 1'b1;
    tick();
    start1 = 1'b0;
    tests++;
    if ({moves1, bank_w1, bank_g1, bank_c1, bank_m1, done1, dep_ready1} !== 14'b00000000_0000_01) begin
      fails++;
      $display("FAIL b2b_restart: moves,banks,done,ready=%b required 00000000_0000_01",
               {moves1, bank_w1, bank_g1, bank_c1, bank_m1, done1, dep_ready1});
    end
  endtask

  initial begin
    test_reset();
    test_auto();
    test_manual_basic();
    test_wrong_bank();
    test_reset_midtrip();
    test_random();
    do_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
